// File: rtl/fab_clk_pkg.sv
// Shared types and constants for the fabric clock/reset sequencer.
package fab_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    SWRST     = 2'd3
  } state_t;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/fab_clk_reset_seq_sync.sv
// 1-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fab_clk_reset_seq.sv
// Holds fabric logic in reset until FAB_CLK is lock-qualified, then issues a
// periodic timebase tick, counts lock-loss events and serves software resets.
module fab_clk_reset_seq
  import fab_clk_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int LOSS_FILTER   = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int TICK_DIV      = 100,
  parameter int CNT_W         = 16
) (
  input  logic       FAB_CLK,
  input  logic       FAB_RESET,
  input  logic       FAB_LOCK,
  input  logic       LOCK_BYPASS,
  input  logic       SW_RESET_REQ,
  output logic       SYS_RESET,
  output logic       SYS_READY,
  output logic       TICK,
  output logic [7:0] LOCK_LOSS_CNT,
  output logic [1:0] STATE
);

  localparam int FILT_W  = $clog2(LOSS_FILTER + 1);
  localparam int PRESC_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST   = FILT_W'(LOSS_FILTER - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_DIV - 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [FILT_W-1:0]  filt, filt_next;
  logic [PRESC_W-1:0] presc, presc_next;
  logic               lock_sync, lock_q, loss, tick_next, stay_run;
  logic               sys_reset, sys_ready, tick;
  logic [7:0]         loss_cnt;

  sync_2ff u_lock_sync (
    .clk (FAB_CLK),
    .rst (FAB_RESET),
    .d   (FAB_LOCK),
    .q   (lock_sync)
  );

  assign lock_q = LOCK_BYPASS | lock_sync;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    filt_next  = '0;
    loss       = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_q) begin
          next_state = STABILIZE;
          cnt_next   = '0;
        end
      end
      STABILIZE: begin
        if (!lock_q) begin
          next_state = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          next_state = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_q) begin
          if (filt == FILT_LAST) begin
            loss       = 1'b1;
            next_state = WAIT_LOCK;
          end else begin
            filt_next = filt + FILT_W'(1);
          end
        end
        // A lock loss in the same cycle swallows the software request.
        if (!loss && SW_RESET_REQ) begin
          next_state = SWRST;
          cnt_next   = '0;
        end
      end
      SWRST: begin
        if (cnt == HOLD_LAST) begin
          next_state = lock_q ? RUN : WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        next_state = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Prescaler and filter only advance while RUN persists across the edge.
  assign stay_run = (state == RUN) && (next_state == RUN);

  always_comb begin
    presc_next = '0;
    tick_next  = 1'b0;
    if (stay_run) begin
      presc_next = (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
      tick_next  = (presc == PRESC_LAST);
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      filt      <= '0;
      presc     <= '0;
      sys_reset <= 1'b1;
      sys_ready <= 1'b0;
      tick      <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      filt      <= stay_run ? filt_next : '0;
      presc     <= presc_next;
      sys_reset <= (next_state != RUN);
      sys_ready <= (next_state == RUN);
      tick      <= tick_next;
      if (loss && (loss_cnt != LOSS_CNT_MAX)) begin
        loss_cnt <= loss_cnt + 8'd1;
      end
    end
  end

  assign SYS_RESET     = sys_reset;
  assign SYS_READY     = sys_ready;
  assign TICK          = tick;
  assign LOCK_LOSS_CNT = loss_cnt;
  assign STATE         = state;

endmodule

// File: tb/tb_fab_clk_reset_seq.sv
// Directed bench for fab_clk_reset_seq: expectations are queued per cycle and
// compared against the outputs sampled on the falling edge of that cycle.
module tb_fab_clk_reset_seq;

  localparam int STABLE_CYCLES = 8;
  localparam int LOSS_FILTER   = 3;
  localparam int HOLD_CYCLES   = 4;
  localparam int TICK_DIV      = 4;

  logic       clk = 1'b0;
  logic       FAB_RESET, FAB_LOCK, LOCK_BYPASS, SW_RESET_REQ;
  logic       SYS_RESET, SYS_READY, TICK;
  logic [7:0] LOCK_LOSS_CNT;
  logic [1:0] STATE;

  fab_clk_reset_seq #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .LOSS_FILTER   (LOSS_FILTER),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TICK_DIV      (TICK_DIV),
    .CNT_W         (16)
  ) dut (
    .FAB_CLK       (clk),
    .FAB_RESET     (FAB_RESET),
    .FAB_LOCK      (FAB_LOCK),
    .LOCK_BYPASS   (LOCK_BYPASS),
    .SW_RESET_REQ  (SW_RESET_REQ),
    .SYS_RESET     (SYS_RESET),
    .SYS_READY     (SYS_READY),
    .TICK          (TICK),
    .LOCK_LOSS_CNT (LOCK_LOSS_CNT),
    .STATE         (STATE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          cyc;
    logic [12:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tph = 0;
  int   lc = 0;

  // Output vector layout: {STATE, SYS_RESET, SYS_READY, TICK, LOCK_LOSS_CNT}
  function automatic logic [12:0] pk(int st, bit sr, bit tk, int cnt);
    logic [1:0] s2;
    logic [7:0] c8;
    s2 = st[1:0];
    c8 = cnt[7:0];
    return {s2, sr, ~sr, tk, c8};
  endfunction

  task automatic ex(string tag, int c, int st, bit sr, bit tk, int cnt);
    exp_t e;
    e.tag = tag;
    e.cyc = c;
    e.val = pk(st, sr, tk, cnt);
    sb.push_back(e);
  endtask

  task automatic ex_run(string tag, int c);
    bit tk;
    tk = (c >= tph) && (((c - tph) % TICK_DIV) == 0);
    ex(tag, c, 2, 1'b0, tk, lc);
  endtask

  task automatic step();
    logic [12:0] obs;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    obs = {STATE, SYS_RESET, SYS_READY, TICK, LOCK_LOSS_CNT};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        assert (obs === sb[i].val) else begin
          failures++;
          $error("FAIL %s cyc=%0d observed=%h expected=%h", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  initial begin
    int c0;
    int st;

    FAB_RESET = 1'b1; FAB_LOCK = 1'b0; LOCK_BYPASS = 1'b0; SW_RESET_REQ = 1'b0;
    ex("reset", 1, 0, 1'b1, 1'b0, 0);
    ex("reset_hold", 3, 0, 1'b1, 1'b0, 0);
    run(3);

    // Lock qualification and first ticks
    FAB_RESET = 1'b0; FAB_LOCK = 1'b1; c0 = cyc;
    ex("t1_wait", c0 + 2, 0, 1'b1, 1'b0, lc);
    ex("t1_stab", c0 + 3, 1, 1'b1, 1'b0, lc);
    ex("t1_stab_end", c0 + 10, 1, 1'b1, 1'b0, lc);
    tph = c0 + 15;
    for (int c = c0 + 11; c <= c0 + 24; c++) ex_run("t1_run", c);
    run(24);

    // Short lock glitch in RUN is filtered
    c0 = cyc; FAB_LOCK = 1'b0;
    for (int c = c0 + 1; c <= c0 + 8; c++) ex_run("t3_glitch", c);
    run(2); FAB_LOCK = 1'b1; run(6);

    // Sustained lock loss in RUN
    c0 = cyc; FAB_LOCK = 1'b0;
    for (int c = c0 + 1; c <= c0 + 4; c++) ex_run("t3_pre_loss", c);
    lc = 1;
    ex("t3_loss", c0 + 5, 0, 1'b1, 1'b0, lc);
    ex("t3_wait", c0 + 7, 0, 1'b1, 1'b0, lc);
    run(7);

    // Lock drop mid-STABILIZE, then full restabilise; SW requests ignored
    c0 = cyc; FAB_LOCK = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      if (c < 3) st = 0;
      else if (c <= 8) st = 1;
      else if (c == 9) st = 0;
      else if (c <= 17) st = 1;
      else st = 2;
      ex("t2_stab", c0 + c, st, (st != 2), 1'b0, lc);
    end
    tph = c0 + 22;
    for (int c = c0 + 19; c <= c0 + 26; c++) ex_run("t2_run", c);
    run(4); SW_RESET_REQ = 1'b1; run(1); SW_RESET_REQ = 1'b0;
    run(1); FAB_LOCK = 1'b0; run(1); FAB_LOCK = 1'b1;
    run(2); SW_RESET_REQ = 1'b1; run(1); SW_RESET_REQ = 1'b0;
    run(16);

    // Software reset with lock held
    run(1);
    c0 = cyc; SW_RESET_REQ = 1'b1;
    for (int c = 1; c <= 4; c++) ex("t4_swrst", c0 + c, 3, 1'b1, 1'b0, lc);
    tph = c0 + 9;
    for (int c = c0 + 5; c <= c0 + 14; c++) ex_run("t4_run", c);
    run(1); SW_RESET_REQ = 1'b0; run(13);

    // SW request coincident with loss declaration
    c0 = cyc; FAB_LOCK = 1'b0;
    for (int c = c0 + 1; c <= c0 + 4; c++) ex_run("t5_pre_loss", c);
    lc = 2;
    ex("t5_loss", c0 + 5, 0, 1'b1, 1'b0, lc);
    ex("t5_wait", c0 + 6, 0, 1'b1, 1'b0, lc);
    run(4); SW_RESET_REQ = 1'b1; run(1); SW_RESET_REQ = 1'b0; run(1);

    // Bypass qualification
    c0 = cyc; LOCK_BYPASS = 1'b1;
    ex("t6_stab", c0 + 1, 1, 1'b1, 1'b0, lc);
    ex("t6_stab_end", c0 + 8, 1, 1'b1, 1'b0, lc);
    ex("t6_run", c0 + 9, 2, 1'b0, 1'b0, lc);
    run(9);

    // Repeated loss events drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      c0 = cyc; LOCK_BYPASS = 1'b0;
      if (lc < 255) lc++;
      ex("t6_loss", c0 + 3, 0, 1'b1, 1'b0, lc);
      ex("t6_rerun", c0 + 12, 2, 1'b0, 1'b0, lc);
      run(3); LOCK_BYPASS = 1'b1; run(9);
    end

    // Reset asserted mid-STABILIZE
    c0 = cyc; LOCK_BYPASS = 1'b0;
    ex("t6_sat_hold", c0 + 3, 0, 1'b1, 1'b0, 255);
    run(3); LOCK_BYPASS = 1'b1; run(4);
    FAB_RESET = 1'b1; lc = 0;
    ex("t6_rst", c0 + 8, 0, 1'b1, 1'b0, 0);
    ex("t6_rst_hold", c0 + 9, 0, 1'b1, 1'b0, 0);
    run(2);
    FAB_RESET = 1'b0;
    ex("t6_post_rst_stab", c0 + 10, 1, 1'b1, 1'b0, 0);
    ex("t6_post_rst_stab_end", c0 + 17, 1, 1'b1, 1'b0, 0);
    ex("t6_post_rst_run", c0 + 18, 2, 1'b0, 1'b0, 0);
    run(9);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d pending expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
